// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction-fetch / data memory-port arbiter:
// FSM encoding, port-owner codes and the registered memory command payload.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MEMOP_W  = 2;
    localparam int unsigned OWNER_W  = 2;
    localparam int unsigned STREAK_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2
    } state_e;

    localparam logic [OWNER_W-1:0] OWN_NONE = 2'd0;
    localparam logic [OWNER_W-1:0] OWN_IF   = 2'd1;
    localparam logic [OWNER_W-1:0] OWN_D    = 2'd2;

    typedef struct packed {
        logic               we;
        logic [MEMOP_W-1:0] memop;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } mem_cmd_t;

    function automatic logic [OWNER_W-1:0] owner_of(input state_e s);
        case (s)
            ST_IF_BUSY: return OWN_IF;
            ST_D_BUSY:  return OWN_D;
            default:    return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared memory-port signals around the arbiter.
// master = the arbiter itself, slave = the CPU requesters plus the memory.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic [DATA_W-1:0]   if_rdata;
    logic                if_ready;

    logic                d_req;
    logic                d_we;
    logic [MEMOP_W-1:0]  d_memop;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_ready;

    logic                mem_req;
    logic                mem_we;
    logic [MEMOP_W-1:0]  mem_memop;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    logic [OWNER_W-1:0]  owner;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_memop, d_addr, d_wdata,
        input  mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready,
        output mem_req, mem_we, mem_memop, mem_addr, mem_wdata, owner
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_memop, d_addr, d_wdata,
        output mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready,
        input  mem_req, mem_we, mem_memop, mem_addr, mem_wdata, owner
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and data access.
// Data normally wins; a saturating streak counter bounds how long fetch can starve.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_MAX);

    state_e              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    mem_cmd_t            cmd_q, cmd_d;
    logic                mem_req_q, mem_req_d;
    logic                if_ready_q, if_ready_d;
    logic                d_ready_q, d_ready_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;

    logic if_elig_c;
    logic d_elig_c;
    logic fetch_wins_c;

    // A requester whose ready is pulsing this cycle must not be regranted.
    assign if_elig_c    = bus.if_req & ~if_ready_q;
    assign d_elig_c     = bus.d_req & ~d_ready_q;
    assign fetch_wins_c = if_elig_c & (~d_elig_c | (streak_q == STREAK_MAX));

    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        cmd_d      = cmd_q;
        mem_req_d  = mem_req_q;
        if_ready_d = 1'b0;
        d_ready_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (fetch_wins_c) begin
                    state_d     = ST_IF_BUSY;
                    mem_req_d   = 1'b1;
                    cmd_d.we    = 1'b0;
                    cmd_d.memop = '0;
                    cmd_d.addr  = bus.if_addr;
                    cmd_d.wdata = '0;
                    streak_d    = '0;
                end else if (d_elig_c) begin
                    state_d     = ST_D_BUSY;
                    mem_req_d   = 1'b1;
                    cmd_d.we    = bus.d_we;
                    cmd_d.memop = bus.d_memop;
                    cmd_d.addr  = bus.d_addr;
                    cmd_d.wdata = bus.d_wdata;
                    if (!bus.if_req) begin
                        streak_d = '0;
                    end else if (streak_q < STREAK_MAX) begin
                        streak_d = streak_q + STREAK_W'(1);
                    end
                end
            end
            ST_IF_BUSY: begin
                if (bus.mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    if_ready_d = 1'b1;
                    if_rdata_d = bus.mem_rdata;
                end
            end
            ST_D_BUSY: begin
                if (bus.mem_ack) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    d_rdata_d = bus.mem_rdata;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        owner_d = owner_of(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            streak_q   <= '0;
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            if_ready_q <= 1'b0;
            d_ready_q  <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            owner_q    <= OWN_NONE;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            if_ready_q <= if_ready_d;
            d_ready_q  <= d_ready_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            owner_q    <= owner_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = cmd_q.we;
    assign bus.mem_memop = cmd_q.memop;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a rule-level arbitration model queues the
// expected grants and completions, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int STARVE   = 1;
    localparam int MAX_WAIT = 50;

    typedef struct packed {
        logic [1:0]  port;
        logic        we;
        logic [1:0]  memop;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [1:0]  port;
        logic [31:0] rdata;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.STARVE_MAX(STARVE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    txn_t  exp_txn[$];
    resp_t exp_resp[$];

    // Reference model: who holds the port, how long fetch has waited, pending pulses.
    int          m_owner    = 0;
    int          m_streak   = 0;
    logic        m_if_rdy   = 1'b0;
    logic        m_d_rdy    = 1'b0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata  = '0;

    // Memory responder controls (written by the stimulus, read by the responder).
    int          delay_sel = -1;
    logic        rdata_fix = 1'b0;
    logic [31:0] rdata_sel = '0;
    logic        spur_ack  = 1'b0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"},   64'(bus.mem_req),   64'd0);
        chk({tag, "_mem_we"},    64'(bus.mem_we),    64'd0);
        chk({tag, "_if_ready"},  64'(bus.if_ready),  64'd0);
        chk({tag, "_d_ready"},   64'(bus.d_ready),   64'd0);
        chk({tag, "_owner"},     64'(bus.owner),     64'(OWN_NONE));
        chk({tag, "_mem_memop"}, 64'(bus.mem_memop), 64'd0);
        chk({tag, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
        chk({tag, "_if_rdata"},  64'(bus.if_rdata),  64'd0);
        chk({tag, "_d_rdata"},   64'(bus.d_rdata),   64'd0);
    endfunction

    // Arbitration rules applied at every clock edge to the sampled requests.
    always @(posedge clk or negedge rst) begin : model
        logic ie;
        logic de;
        txn_t t;
        if (!rst) begin
            m_owner = 0; m_streak = 0; m_if_rdy = 1'b0; m_d_rdy = 1'b0;
            m_if_rdata = '0; m_d_rdata = '0;
            exp_txn.delete();
            exp_resp.delete();
        end else begin
            ie = bus.if_req && !m_if_rdy;
            de = bus.d_req && !m_d_rdy;
            m_if_rdy = 1'b0;
            m_d_rdy  = 1'b0;
            if (m_owner == 0) begin
                if (de && !(m_streak == STARVE && ie)) begin
                    t = '{port: 2'd2, we: bus.d_we, memop: bus.d_memop, addr: bus.d_addr, wdata: bus.d_wdata};
                    exp_txn.push_back(t);
                    m_owner  = 2;
                    m_streak = bus.if_req ? ((m_streak + 1 > STARVE) ? STARVE : m_streak + 1) : 0;
                end else if (ie) begin
                    t = '{port: 2'd1, we: 1'b0, memop: 2'd0, addr: bus.if_addr, wdata: 32'd0};
                    exp_txn.push_back(t);
                    m_owner  = 1;
                    m_streak = 0;
                end
            end else if (bus.mem_ack) begin
                if (m_owner == 1) begin
                    m_if_rdy = 1'b1; m_if_rdata = bus.mem_rdata;
                end else begin
                    m_d_rdy = 1'b1; m_d_rdata = bus.mem_rdata;
                end
                exp_resp.push_back('{port: 2'(m_owner), rdata: bus.mem_rdata});
                m_owner = 0;
            end
        end
    end

    // Memory: acks each new mem_req after 0..5 extra cycles; keeps counting across resets.
    always @(negedge clk) begin : responder
        logic r_prev;
        logic r_pend;
        int   r_cnt;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = rdata_fix ? rdata_sel : $urandom;
        if (bus.mem_req === 1'b1 && r_prev !== 1'b1) begin
            r_pend = 1'b1;
            r_cnt  = (delay_sel < 0) ? int'($urandom_range(0, 5)) : delay_sel;
        end
        if (r_pend === 1'b1) begin
            if (r_cnt == 0) begin
                bus.mem_ack = 1'b1;
                r_pend      = 1'b0;
            end else begin
                r_cnt--;
            end
        end
        if (spur_ack) bus.mem_ack = 1'b1;
        r_prev = bus.mem_req;
    end

    always @(negedge clk) begin : monitor
        logic  mon_prev;
        logic  have_cur;
        txn_t  cur;
        resp_t r;
        if (!rst) begin
            chk_reset_outputs("rst");
            mon_prev = 1'b0;
            have_cur = 1'b0;
        end else begin
            chk("owner",    64'(bus.owner),    64'(m_owner));
            chk("mem_req",  64'(bus.mem_req),  64'(m_owner != 0));
            chk("if_ready", 64'(bus.if_ready), 64'(m_if_rdy));
            chk("d_ready",  64'(bus.d_ready),  64'(m_d_rdy));
            chk("if_rdata", 64'(bus.if_rdata), 64'(m_if_rdata));
            chk("d_rdata",  64'(bus.d_rdata),  64'(m_d_rdata));
            if (bus.mem_req && !mon_prev) begin
                if (exp_txn.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL grant_unexpected: got mem_req=1 addr 0x%0h expected no grant at %0t", bus.mem_addr, $time);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_txn.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (bus.mem_req && have_cur) begin
                chk("grant_owner", 64'(bus.owner),     64'(cur.port));
                chk("mem_addr",    64'(bus.mem_addr),  64'(cur.addr));
                chk("mem_we",      64'(bus.mem_we),    64'(cur.we));
                chk("mem_memop",   64'(bus.mem_memop), 64'(cur.memop));
                if (cur.port == 2'd2) chk("mem_wdata", 64'(bus.mem_wdata), 64'(cur.wdata));
            end
            if (bus.if_ready || bus.d_ready) begin
                if (exp_resp.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL ready_unexpected: got if_ready=%0b d_ready=%0b expected no completion at %0t",
                             bus.if_ready, bus.d_ready, $time);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_port",  bus.if_ready ? 64'd1 : 64'd2, 64'(r.port));
                    chk("resp_rdata", 64'(bus.if_ready ? bus.if_rdata : bus.d_rdata), 64'(r.rdata));
                end
            end
            mon_prev = bus.mem_req;
        end
    end

    task automatic wait_ready(input int which, input string name, output int cycles);
        bit hit = 1'b0;
        cycles = 0;
        while (!hit && cycles < MAX_WAIT) begin
            @(negedge clk);
            cycles++;
            hit = (which == 1) ? bus.if_ready : bus.d_ready;
        end
        if (!hit) begin
            n_checks++; n_errors++;
            $display("FAIL %s: got no ready pulse within %0d cycles expected one", name, cycles);
        end
    endtask

    task automatic new_d_fields();
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_memop = 2'($urandom_range(0, 3));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.if_req) begin
                if (bus.if_ready) begin
                    if ($urandom_range(0, 1) == 0) bus.if_req = 1'b0;
                    else bus.if_addr = $urandom;
                end else if ($urandom_range(0, 3) == 0) bus.if_addr = $urandom;
            end else if ($urandom_range(0, 2) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = $urandom;
            end
            if (bus.d_req) begin
                if (bus.d_ready) begin
                    if ($urandom_range(0, 1) == 0) bus.d_req = 1'b0;
                    else new_d_fields();
                end else if ($urandom_range(0, 3) == 0) new_d_fields();
            end else if ($urandom_range(0, 2) == 0) begin
                bus.d_req = 1'b1;
                new_d_fields();
            end
        end
    endtask

    task automatic drain(input string tag);
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (12) @(negedge clk);
        chk({tag, "_owner_idle"},   64'(bus.owner),       64'(OWN_NONE));
        chk({tag, "_txn_q_empty"},  64'(exp_txn.size()),  64'd0);
        chk({tag, "_resp_q_empty"}, 64'(exp_resp.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        int ready_cnt;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_memop = '0; bus.d_addr = '0; bus.d_wdata = '0;
        #1 rst = 1'b0;
        #2 chk_reset_outputs("init");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Fetch only, ack one cycle after mem_req rises.
        @(negedge clk);
        rdata_fix = 1'b1; rdata_sel = 32'h2008_0005; delay_sel = 1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
        @(negedge clk);
        chk("fetch_mem_we",   64'(bus.mem_we),   64'd0);
        chk("fetch_mem_addr", 64'(bus.mem_addr), 64'h10);
        wait_ready(1, "fetch_only", cyc);
        chk("fetch_latency", 64'(cyc), 64'd2);
        chk("fetch_rdata",   64'(bus.if_rdata), 64'h2008_0005);
        bus.if_req = 1'b0; rdata_fix = 1'b0; delay_sel = -1;

        // Simultaneous requests: data first, fetch right after d_ready.
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h24;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h40; bus.d_wdata = 32'hDEAD_BEEF; bus.d_memop = 2'b10;
        @(negedge clk);
        chk("simul_first_owner", 64'(bus.owner),    64'(OWN_D));
        chk("simul_first_we",    64'(bus.mem_we),   64'd1);
        chk("simul_first_addr",  64'(bus.mem_addr), 64'h40);
        wait_ready(2, "simul_data", cyc);
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("simul_second_owner", 64'(bus.owner),    64'(OWN_IF));
        chk("simul_second_addr",  64'(bus.mem_addr), 64'h24);
        wait_ready(1, "simul_fetch", cyc);
        bus.if_req = 1'b0;

        // Wait states: d_addr toggles while the ack is 5 cycles late.
        @(negedge clk);
        delay_sel = 5;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_memop = 2'b01;
        @(negedge clk);
        chk("ws_mem_req", 64'(bus.mem_req), 64'd1);
        cyc = 0;
        while (!bus.d_ready && cyc < MAX_WAIT) begin
            chk("ws_addr_hold", 64'(bus.mem_addr), 64'h100);
            bus.d_addr = ~bus.d_addr;
            @(negedge clk);
            cyc++;
        end
        chk("ws_latency", 64'(cyc), 64'd6);
        bus.d_req = 1'b0;

        // Reset in the middle of a data transaction; its late ack must be ignored.
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h200; bus.d_wdata = $urandom;
        @(negedge clk);
        chk("abort_pre_owner", 64'(bus.owner), 64'(OWN_D));
        #2 rst = 1'b0;
        #1 chk_reset_outputs("abort");
        bus.d_req = 1'b0;
        @(negedge clk);
        rst = 1'b1; delay_sel = -1;
        ready_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.if_ready || bus.d_ready) ready_cnt++;
        end
        chk("abort_no_ready",   64'(ready_cnt), 64'd0);
        chk("abort_owner_idle", 64'(bus.owner), 64'(OWN_NONE));

        // Spurious ack in IDLE.
        @(negedge clk);
        spur_ack = 1'b1;
        @(negedge clk);
        spur_ack = 1'b0;
        chk("spur_owner",    64'(bus.owner),    64'(OWN_NONE));
        chk("spur_mem_req",  64'(bus.mem_req),  64'd0);
        chk("spur_if_ready", 64'(bus.if_ready), 64'd0);
        chk("spur_d_ready",  64'(bus.d_ready),  64'd0);
        @(negedge clk);
        chk("spur_owner_after", 64'(bus.owner), 64'(OWN_NONE));

        rand_cycles(3000);
        drain("rand1");
        rand_cycles(2000);
        drain("rand2");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, SHALL set the maximum consecutive data grants while a fetch request waits.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 if_req  in  1  instruction-fetch request, held high until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetched instruction, valid while if_ready.
REQ-008 if_ready  out  1  one-cycle fetch completion pulse.
REQ-009 d_req  in  1  data (load/store) request, held high until d_ready.
REQ-010 d_we  in  1  1 = store, 0 = load.
REQ-011 d_memop  in  2  access size code, passed through unchanged.
REQ-012 d_addr, d_wdata  in  32 each  data address and store data.
REQ-013 d_rdata  out  32  load data, valid while d_ready.
REQ-014 d_ready  out  1  one-cycle data completion pulse.
REQ-015 mem_req, mem_we  out  1 each  shared-port request and write enable.
REQ-016 mem_memop  out  2  access size code driven to the memory.
REQ-017 mem_addr, mem_wdata  out  32 each  shared-port address and write data.
REQ-018 mem_rdata  in  32  memory read data, valid with mem_ack.
REQ-019 mem_ack  in  1  one-cycle memory completion, arriving one or more cycles after mem_req rises.
REQ-020 owner  out  2  current port owner: 0 = none, 1 = fetch, 2 = data.

Function
REQ-021 The FSM SHALL have three states: IDLE, IF_BUSY and D_BUSY.
REQ-022 In IDLE, an eligible d_req SHALL win, unless streak == STARVE_MAX and if_req is high; in that case fetch SHALL win.
REQ-023 In IDLE with only an eligible if_req, the FSM SHALL go to IF_BUSY; with no eligible request it SHALL stay in IDLE.
REQ-024 On grant, the winner's address, wdata, we and memop SHALL be registered; fetch grants SHALL force we = 0 and memop = 2'b00.
REQ-025 mem_req and the registered mem_* fields SHALL be high/valid from the cycle after grant and held stable until the cycle mem_ack is sampled.
REQ-026 When mem_ack is sampled in a BUSY state, mem_req SHALL drop next cycle, mem_rdata SHALL be registered into the matching rdata output, the matching ready SHALL pulse for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-027 Minimum latency SHALL be 2 cycles from grant to ready pulse, that is, when mem_ack arrives in the first BUSY cycle.
REQ-028 A requester SHALL be ineligible in the cycle its ready pulses, so a still-high req is not regranted.
REQ-029 mem_ack SHALL be ignored in IDLE.
REQ-030 if_rdata and d_rdata SHALL hold their last value between completions.
REQ-031 streak is a 3-bit saturating counter with the following rules.
- It SHALL increment on each data grant while if_req is high.
- It SHALL clear on a fetch grant, or on a data grant while if_req is low.
- It SHALL saturate at STARVE_MAX.
REQ-032 Request changes during BUSY SHALL NOT affect the registered mem_* fields.
REQ-033 owner SHALL equal 1 in IF_BUSY, 2 in D_BUSY and 0 in IDLE.

Reset
REQ-034 While rst is low, the block SHALL enter IDLE immediately (asynchronously), including mid-transaction.
REQ-035 While rst is low, the following SHALL hold: mem_req = 0, mem_we = 0, if_ready = 0, d_ready = 0, owner = 0, streak = 0.
REQ-036 While rst is low, all 32-bit outputs and mem_memop SHALL be 0.
REQ-037 A mem_ack arriving after a reset abort SHALL be ignored.

Structure
REQ-038 The state encoding and the owner codes (OWN_NONE, OWN_IF, OWN_D) SHALL live in the shared CPU package.
REQ-039 The block SHALL be a single module with no sub-module; the FSM, the capture registers and the streak counter are all inline.

Verification
REQ-040 Fetch only: if_req with if_addr = 0x0000_0010, mem_ack 1 cycle after mem_req, mem_rdata = 0x2008_0005 -> if_ready one cycle, if_rdata = 0x2008_0005, mem_we = 0.
REQ-041 Simultaneous requests: if_req and d_req (store, d_addr = 0x40, d_wdata = 0xDEAD_BEEF) in the same cycle -> data granted first with mem_we = 1 and mem_addr = 0x40; fetch granted after d_ready.
REQ-042 Starvation: d_req held high with if_req high, STARVE_MAX = 4 -> exactly 4 data grants, then a fetch grant, then data resumes.
REQ-043 Wait states: mem_ack delayed 5 cycles while d_addr toggles -> mem_addr stays at the captured value; d_ready appears 6 cycles after mem_req.
REQ-044 Reset mid-transaction: rst low during D_BUSY -> mem_req = 0 and owner = 0 in the same cycle; a later mem_ack produces no ready pulse.
REQ-045 Spurious ack: mem_ack pulsed in IDLE -> no ready pulse and no state change.
